// File: rtl/event_addr_fifo.sv
// rtl/event_addr_fifo.sv - pixel event address former, timestamp tagger and FWFT event FIFO
//
// Purpose: turns the granted level-1 group plus the in-group offset into an
// absolute {row, col}. It tags the event with a free-running timestamp, stores it
// in a first-word-fall-through FIFO, and then pulses a group release back to the
// arbiter.
//
// Ports:
//   clk_i, reset_i        clock (rising edge) and asynchronous active-high reset
//   active_i              level-1 stage presents a granted pixel
//   gnt_top_i[r][c]       top-level group grant, one-hot while active_i=1
//   x_add_i, y_add_i      column / row offset inside the granted group
//   grp_release_o         one-cycle pulse after an event has been stored
//   evt_valid_o/ready_i   FIFO head handshake
//   evt_data_o            {timestamp, row, col}; zero while the FIFO is empty
//   fifo_full_o           occupancy == FIFO_DEPTH
//   stall_o               an event is waiting in IDLE but the FIFO is full
//   err_o                 sticky: active_i seen with a non one-hot grant
//   fifo_count_o          current occupancy
module event_addr_fifo #(
  parameter int PIXELS     = 16,
  parameter int GROUP_SIZE = 2,
  parameter int CONST      = PIXELS / GROUP_SIZE,
  parameter int LOC_W      = $clog2(GROUP_SIZE),
  parameter int ADDR_W     = $clog2(PIXELS),
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = TS_WIDTH + 2 * ADDR_W
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            active_i,
  input  logic [CONST-1:0][CONST-1:0]     gnt_top_i,
  input  logic [LOC_W-1:0]                x_add_i,
  input  logic [LOC_W-1:0]                y_add_i,
  output logic                            grp_release_o,
  output logic                            evt_valid_o,
  input  logic                            evt_ready_i,
  output logic [DATA_W-1:0]               evt_data_o,
  output logic                            fifo_full_o,
  output logic                            stall_o,
  output logic                            err_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GW    = ADDR_W - LOC_W;
  localparam int NG    = CONST * CONST;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  logic [1:0]              r_state;
  logic [TS_WIDTH-1:0]     r_ts;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    r_err;
  logic [DATA_W-1:0]       r_mem [FIFO_DEPTH];

  logic [NG-1:0]           w_gnt_flat;
  logic                    w_onehot;
  logic [GW-1:0]           w_gr;
  logic [GW-1:0]           w_gc;
  logic [ADDR_W-1:0]       w_row;
  logic [ADDR_W-1:0]       w_col;
  logic [DATA_W-1:0]       w_word;
  logic                    w_idle;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;

  assign w_gnt_flat = gnt_top_i;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign w_onehot = (w_gnt_flat != '0) && ((w_gnt_flat & (w_gnt_flat - NG'(1))) == '0);

  // OR-reduction encoder; only meaningful when the grant is one-hot.
  always_comb begin
    w_gr = '0;
    w_gc = '0;
    for (int r = 0; r < CONST; r++) begin
      for (int c = 0; c < CONST; c++) begin
        if (gnt_top_i[r][c]) begin
          w_gr = w_gr | GW'(r);
          w_gc = w_gc | GW'(c);
        end
      end
    end
  end

  // GROUP_SIZE is a power of two, so index*GROUP_SIZE + offset is a concatenation.
  assign w_row  = {w_gr, y_add_i};
  assign w_col  = {w_gc, x_add_i};
  assign w_word = {r_ts, w_row, w_col};

  assign w_idle = (r_state == S_IDLE);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push = w_idle && active_i && w_onehot && !w_full;
  assign w_pop  = (r_count != '0) && evt_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_ts     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);

      case (r_state)
        S_IDLE:    if (w_push) r_state <= S_RELEASE;
        S_RELEASE: r_state <= S_HOLDOFF;
        S_HOLDOFF: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase

      if (w_idle && active_i && !w_onehot) r_err <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  assign grp_release_o = (r_state == S_RELEASE);
  assign evt_valid_o   = (r_count != '0);
  assign evt_data_o    = evt_valid_o ? r_mem[r_rd_ptr] : '0;
  assign fifo_full_o   = w_full;
  assign stall_o       = w_idle && active_i && w_full;
  assign err_o         = r_err;
  assign fifo_count_o  = r_count;

endmodule

// File: tb/tb_event_addr_fifo.sv
// tb/tb_event_addr_fifo.sv - self-checking bench for event_addr_fifo
module tb_event_addr_fifo;

  logic             clk = 1'b0;
  logic             rst;
  logic             active;
  logic [7:0][7:0]  gnt;
  logic             x_add;
  logic             y_add;
  logic             ready;

  logic             rel, valid, full, stall, err;
  logic [23:0]      data;
  logic [3:0]       count;

  logic             rel2, valid2, full2, stall2, err2;
  logic [11:0]      data2;
  logic [3:0]       count2;

  int n_pass = 0;
  int n_tot  = 0;

  // reference model state
  logic [23:0] q[$];
  int          m_ts;
  int          m_busy;
  bit          m_err;
  bit          m_rel;
  int          cur_gr;
  int          cur_gc;

  always #5 clk = ~clk;

  event_addr_fifo dut (
    .clk_i(clk), .reset_i(rst), .active_i(active), .gnt_top_i(gnt),
    .x_add_i(x_add), .y_add_i(y_add), .grp_release_o(rel),
    .evt_valid_o(valid), .evt_ready_i(ready), .evt_data_o(data),
    .fifo_full_o(full), .stall_o(stall), .err_o(err), .fifo_count_o(count)
  );

  event_addr_fifo #(.TS_WIDTH(4)) dut_ts4 (
    .clk_i(clk), .reset_i(rst), .active_i(active), .gnt_top_i(gnt),
    .x_add_i(x_add), .y_add_i(y_add), .grp_release_o(rel2),
    .evt_valid_o(valid2), .evt_ready_i(ready), .evt_data_o(data2),
    .fifo_full_o(full2), .stall_o(stall2), .err_o(err2), .fifo_count_o(count2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic set_ev(input int gr, input int gc, input int x, input int y);
    gnt = '0;
    gnt[gr][gc] = 1'b1;
    cur_gr = gr;
    cur_gc = gc;
    x_add = 1'(x);
    y_add = 1'(y);
  endtask

  task automatic check_outs();
    logic [23:0] head;
    head = (q.size() != 0) ? q[0] : 24'h0;
    check("release", 32'(rel), 32'(m_rel));
    check("valid", 32'(valid), 32'(q.size() != 0));
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == 8));
    check("err", 32'(err), 32'(m_err));
    check("data", 32'(data), 32'(head));
    check("data_ts4", 32'(data2), 32'(head[11:0]));
  endtask

  // One clock: check combinational stall, advance the model over the edge, check outputs.
  task automatic cycle();
    bit onehot, idle, push, pop, bad;
    logic [23:0] w;
    #1;
    onehot = ($countones(gnt) == 1);
    idle   = (m_busy == 0);
    push   = idle && active && onehot && (q.size() < 8);
    pop    = (q.size() > 0) && ready;
    bad    = idle && active && !onehot;
    check("stall", 32'(stall), 32'(idle && active && q.size() == 8));
    w = {16'(m_ts), 4'(cur_gr * 2 + int'(y_add)), 4'(cur_gc * 2 + int'(x_add))};
    @(posedge clk);
    if (pop) q.delete(0);
    if (push) q.push_back(w);
    m_ts++;
    m_busy = push ? 2 : ((m_busy > 0) ? m_busy - 1 : 0);
    if (bad) m_err = 1'b1;
    m_rel = push;
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_release", 32'(rel), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_data", 32'(data), 0);
    check("rst_full", 32'(full), 0);
    check("rst_err", 32'(err), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ts = 0; m_busy = 0; m_err = 1'b0; m_rel = 1'b0;
  endtask

  // Hold the event upstream until its release pulse (bounded).
  task automatic send_event(input int gr, input int gc, input int x, input int y);
    set_ev(gr, gc, x, y);
    active = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (m_rel) break;
    end
    if (!m_rel) check("send_timeout", 0, 1);
    active = 1'b0;
  endtask

  task automatic send_rand();
    send_event($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  task automatic idle_to(input int mask, input int val);
    for (int k = 0; k < 40 && ((m_ts & mask) != val); k++) cycle();
  endtask

  initial begin
    rst = 1'b1; active = 1'b0; gnt = '0; x_add = 1'b0; y_add = 1'b0; ready = 1'b0;
    cur_gr = 0; cur_gc = 0;
    @(negedge clk);
    do_reset();

    // basic capture at ts=10, grant [2][5], x=1, y=0
    ready = 1'b1;
    idle_to(32'hFFFF, 10);
    set_ev(2, 5, 1, 0);
    active = 1'b1;
    cycle();
    active = 1'b0;
    check("t1_release", 32'(rel), 1);
    check("t1_data", 32'(data), 32'h000A4B);
    cycle();
    check("t1_count", 32'(count), 0);
    check("t1_release_off", 32'(rel), 0);

    // fill to full, stall the ninth, release it with a single pop, drain in order
    ready = 1'b0;
    repeat (8) send_rand();
    cycle(); cycle();
    check("t2_full", 32'(full), 1);
    check("t2_count", 32'(count), 8);
    set_ev(7, 7, 1, 1);
    active = 1'b1;
    repeat (4) cycle();
    check("t2_stall", 32'(stall), 1);
    check("t2_no_release", 32'(rel), 0);
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    check("t2_count_after_pop", 32'(count), 7);
    cycle();
    check("t2_ninth_release", 32'(rel), 1);
    check("t2_count_refill", 32'(count), 8);
    active = 1'b0;
    ready = 1'b1;
    repeat (12) cycle();

    // non one-hot grant sets a sticky error and pushes nothing
    gnt = '0;
    gnt[0][0] = 1'b1;
    gnt[1][1] = 1'b1;
    active = 1'b1;
    cycle();
    active = 1'b0;
    check("t3_err", 32'(err), 1);
    check("t3_count", 32'(count), 0);
    check("t3_no_release", 32'(rel), 0);
    repeat (3) cycle();
    check("t3_err_sticky", 32'(err), 1);
    do_reset();

    // 4-bit timestamp wrap: captures at 15 then 2
    ready = 1'b0;
    idle_to(15, 15);
    send_event(3, 1, 0, 1);
    idle_to(15, 2);
    send_event(4, 6, 1, 1);
    check("t4_ts_first", 32'(data2[11:8]), 15);
    ready = 1'b1;
    cycle();
    check("t4_ts_second", 32'(data2[11:8]), 2);
    repeat (4) cycle();

    // push and pop in the same cycle at count 3
    do_reset();
    ready = 1'b0;
    repeat (3) send_rand();
    cycle(); cycle();
    check("t5_count_pre", 32'(count), 3);
    set_ev(5, 2, 0, 0);
    active = 1'b1;
    ready = 1'b1;
    cycle();
    active = 1'b0;
    ready = 1'b0;
    check("t5_release", 32'(rel), 1);
    check("t5_count", 32'(count), 3);

    // reset while in RELEASE with five stored events
    do_reset();
    ready = 1'b0;
    repeat (5) send_rand();
    check("t6_count", 32'(count), 5);
    check("t6_in_release", 32'(rel), 1);
    do_reset();
    set_ev(1, 1, 0, 0);
    active = 1'b1;
    cycle();
    active = 1'b0;
    check("t6_ts_restart", 32'(data[23:8]), 0);

    // randomized traffic; an event stays asserted upstream until released
    for (int n = 0; n < 400; n++) begin
      ready = 1'($urandom_range(0, 1));
      if (m_rel || !active) begin
        active = ($urandom_range(0, 2) != 0);
        set_ev($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
      end
      cycle();
    end
    active = 1'b0;
    ready = 1'b1;
    repeat (10) cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/event_addr_fifo.md
Name: event_addr_fifo

Overview:
- Sits directly downstream of the level-1 pixel group stage.
- Accepts the granted group (one-hot top grant) and the in-group x/y offset, and forms the absolute pixel row/column.
- Tags each event with a free-running timestamp and buffers it in a first-word-fall-through FIFO with a valid/ready output.
- Pulses a group-release back to the arbiter hierarchy once the event is safely stored.

Parameters:
- PIXELS, 16, pixel array dimension (PIXELS x PIXELS).
- GROUP_SIZE, 2, group edge length (power of 2).
- CONST, PIXELS/GROUP_SIZE, groups per row/column.
- LOC_W, $clog2(GROUP_SIZE), in-group offset width.
- ADDR_W, $clog2(PIXELS), absolute row/column width.
- TS_WIDTH, 16, timestamp width.
- FIFO_DEPTH, 8, event entries (power of 2, >=2).
- DATA_W, TS_WIDTH+2*ADDR_W, event word width.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- active_i  in  1  level-1 stage has a granted active pixel.
- gnt_top_i  in  [CONST-1:0][CONST-1:0]  top-level group grant; one-hot when active_i=1.
- x_add_i  in  LOC_W  column offset inside the granted group.
- y_add_i  in  LOC_W  row offset inside the granted group.
- grp_release_o  out  1  one-cycle pulse: event captured, arbiter may advance.
- evt_valid_o  out  1  FIFO head valid.
- evt_ready_i  in  1  consumer accepts the head word.
- evt_data_o  out  DATA_W  {timestamp, row, col}, with timestamp in the MSBs.
- fifo_full_o  out  1  count == FIFO_DEPTH.
- stall_o  out  1  active_i=1 in IDLE while full.
- err_o  out  1  sticky: active_i=1 with gnt_top_i not one-hot.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, reset_i=1): FSM=IDLE, timestamp=0, FIFO rd/wr pointers and count=0, err_o=0. All outputs are 0, including evt_data_o.
- Timestamp: free-running, +1 every cycle, wraps 2^TS_WIDTH-1 -> 0. The captured value is the counter value in the capture cycle (before increment).
- Address: the granted group is at index (gr, gc) with gnt_top_i[gr][gc]=1.
  - row = gr*GROUP_SIZE + y_add_i.
  - col = gc*GROUP_SIZE + x_add_i.
  - Both are unsigned and ADDR_W wide; no overflow is possible.
- FSM, three states:
  - IDLE:
    - active_i=1, gnt_top_i one-hot, count<FIFO_DEPTH: push {ts,row,col}, go to RELEASE.
    - active_i=1, not one-hot: set err_o, no push, stay in IDLE.
    - active_i=1, full: stall_o=1, no push, stay in IDLE. The event is held upstream, never dropped.
  - RELEASE: grp_release_o=1 for exactly this cycle, go to HOLDOFF. active_i is ignored.
  - HOLDOFF: one cycle while the arbiter re-evaluates; active_i is ignored; go to IDLE.
  - Minimum spacing between captures is therefore 3 cycles.
- Latency: capture edge at end of cycle N. grp_release_o and evt_valid_o (if FIFO was empty) are high in cycle N+1.
- FIFO is first-word-fall-through:
  - evt_data_o = head entry whenever evt_valid_o=1, and holds stable until accepted.
  - evt_valid_o = (count != 0).
  - Pop occurs when evt_valid_o && evt_ready_i.
- Full decision uses the registered count. When full, no push occurs even if a pop happens in the same cycle.
- Simultaneous push and pop with count in 1..FIFO_DEPTH-1: count unchanged and both pointers advance.
- Pop when empty: ignored.
- Pointers wrap modulo FIFO_DEPTH.
- err_o clears only on reset.
- Reset mid-operation: an in-flight RELEASE pulse is suppressed, the FIFO contents are discarded, and the timestamp restarts at 0.

Test Plan:
- Reset, evt_ready_i=1. Cycle with ts=10, gnt_top_i[2][5]=1, x_add_i=1, y_add_i=0, active_i=1 -> next cycle grp_release_o=1 for 1 cycle, evt_valid_o=1, evt_data_o={16'd10, 4'd4, 4'd11}; popped, count returns to 0.
- evt_ready_i=0, 8 back-to-back events -> fifo_full_o=1, count=8. Ninth active_i holds -> stall_o=1, no grp_release_o. Then one pop -> ninth captured within 1 cycle, release follows, data order preserved on drain.
- active_i=1 with gnt_top_i[0][0]=gnt_top_i[1][1]=1 -> err_o=1 and stays 1, count stays 0, no release.
- TS_WIDTH=4: capture at ts=15 and at ts=2 (after wrap) -> timestamps 15 then 2 in FIFO order.
- Count=3, evt_ready_i=1, new capture in same cycle as pop -> count stays 3, head advances.
- Assert reset_i for 1 cycle while in RELEASE with count=5 -> grp_release_o=0 that cycle, count=0, evt_valid_o=0, ts restarts 0.
